// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler.
// Optional same-cycle bypass is enabled by defining BP_UPD_BYPASS_EN.
package bp_update_scheduler_pkg;

    localparam int FETCH_WIDTH  = 2;
    localparam int ADDR         = 32;
    localparam int HISTORY_BITS = 8;

    typedef struct packed {
        logic                    is_cond;
        logic                    taken;
        logic                    gshare_pred;
        logic                    bi_pred;
        logic                    mispredict;
        logic [ADDR-1:0]         pc;
        logic [ADDR-1:0]         target;
        logic [HISTORY_BITS-1:0] history;
    } bp_update_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Execute-side resolution bus, predictor update port and clear port.
// master = execute/driver side, slave = scheduler.
interface bp_update_scheduler_if
    import bp_update_scheduler_pkg::*;
#(
    parameter int W          = FETCH_WIDTH,
    parameter int INDEX_BITS = 4
);
    logic [W-1:0]                   ex_valid_i;
    logic [W-1:0]                   ex_is_cond_i;
    logic [W-1:0]                   ex_taken_i;
    logic [W-1:0][ADDR-1:0]         ex_pc_i;
    logic [W-1:0][ADDR-1:0]         ex_target_i;
    logic [W-1:0][HISTORY_BITS-1:0] ex_history_i;
    logic [W-1:0]                   ex_gshare_pred_i;
    logic [W-1:0]                   ex_bi_pred_i;
    logic [W-1:0]                   ex_mispredict_i;
    logic                           ex_ready_o;

    logic                    upd_valid_o;
    logic                    upd_is_cond_o;
    logic                    upd_taken_o;
    logic                    upd_gshare_pred_o;
    logic                    upd_bi_pred_o;
    logic                    upd_mispredict_o;
    logic [ADDR-1:0]         upd_pc_o;
    logic [ADDR-1:0]         upd_target_o;
    logic [HISTORY_BITS-1:0] upd_history_o;

    logic                  clr_valid_o;
    logic [INDEX_BITS-1:0] clr_idx_o;
    logic [7:0]            ovf_cnt_o;

    modport master (
        output ex_valid_i, ex_is_cond_i, ex_taken_i, ex_pc_i,
        output ex_target_i, ex_history_i, ex_gshare_pred_i,
        output ex_bi_pred_i, ex_mispredict_i,
        input  ex_ready_o,
        input  upd_valid_o, upd_is_cond_o, upd_taken_o,
        input  upd_gshare_pred_o, upd_bi_pred_o, upd_mispredict_o,
        input  upd_pc_o, upd_target_o, upd_history_o,
        input  clr_valid_o, clr_idx_o, ovf_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_is_cond_i, ex_taken_i, ex_pc_i,
        input  ex_target_i, ex_history_i, ex_gshare_pred_i,
        input  ex_bi_pred_i, ex_mispredict_i,
        output ex_ready_o,
        output upd_valid_o, upd_is_cond_o, upd_taken_o,
        output upd_gshare_pred_o, upd_bi_pred_o, upd_mispredict_o,
        output upd_pc_o, upd_target_o, upd_history_o,
        output clr_valid_o, clr_idx_o, ovf_cnt_o
    );
endinterface

// File: rtl/bp_update_fifo.sv
// W-write / 1-read circular buffer; enabled lanes are packed into
// consecutive slots starting at the tail.
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int W     = FETCH_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [W-1:0]             wr_en,
    input  bp_update_t [W-1:0]       wr_data,
    input  logic                     rd_en,
    output bp_update_t               rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    bp_update_t     mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  slot [W];
    logic [PW:0]    enq_n;

    // Slot of each lane = tail + number of enabled lanes below it.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < W; i++) begin
            slot[i] = tail + enq_n[PW-1:0];
            enq_n   = enq_n + (PW+1)'(wr_en[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (wr_en[i]) mem[slot[i]] <= wr_data[i];
            end
            tail  <= tail + enq_n[PW-1:0];
            head  <= head + PW'(rd_en);
            count <= count + enq_n - (PW+1)'(rd_en);
        end
    end

    assign rd_data = mem[head];

endmodule

// File: rtl/bp_update_scheduler.sv
// Funnels resolved branches into the single predictor update port,
// after a post-reset table clear. Bypass: BP_UPD_BYPASS_EN.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int W          = FETCH_WIDTH,
    parameter int DEPTH      = 8,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    bp_update_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_BITS-1:0]  clr_idx;
    logic [7:0]             ovf_cnt;
    logic [8:0]             ovf_sum;
    logic [CW-1:0]          count;
    logic [CW-1:0]          surv_n;
    logic [W:0]             kill;
    logic [W-1:0]           survive;
    logic [W-1:0]           wr_en;
    bp_update_t [W-1:0]     lane;
    bp_update_t             head;
    bp_update_t             upd;
    logic                   ready;
    logic                   run;
    logic                   deq;
    logic                   byp_en;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            lane[i].is_cond     = bus.ex_is_cond_i[i];
            lane[i].taken       = bus.ex_taken_i[i];
            lane[i].gshare_pred = bus.ex_gshare_pred_i[i];
            lane[i].bi_pred     = bus.ex_bi_pred_i[i];
            lane[i].mispredict  = bus.ex_mispredict_i[i];
            lane[i].pc          = bus.ex_pc_i[i];
            lane[i].target      = bus.ex_target_i[i];
            lane[i].history     = bus.ex_history_i[i];
        end
    end

    // Everything younger than the first mispredicting lane is wrong-path.
    always_comb begin
        kill[0] = 1'b0;
        surv_n  = '0;
        for (int i = 0; i < W; i++) begin
            survive[i] = bus.ex_valid_i[i] & ~kill[i];
            kill[i+1]  = kill[i] |
                         (bus.ex_valid_i[i] & bus.ex_mispredict_i[i]);
            surv_n     = surv_n + CW'(survive[i]);
        end
    end

    assign run   = (state == ST_RUN);
    assign ready = (CW'(DEPTH) - count) >= CW'(W);
    assign deq   = run && (count != '0);

`ifdef BP_UPD_BYPASS_EN
    logic [W-1:0] byp_sel;
    bp_update_t   byp_data;

    always_comb begin
        byp_sel  = '0;
        byp_data = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (survive[i]) begin
                byp_sel    = '0;
                byp_sel[i] = 1'b1;
                byp_data   = lane[i];
            end
        end
    end

    assign byp_en = run && (count == '0) && (|survive);
    assign wr_en  = ready ? (survive & ~(byp_en ? byp_sel : '0)) : '0;
    assign upd    = byp_en ? byp_data : head;
`else
    assign byp_en = 1'b0;
    assign wr_en  = ready ? survive : '0;
    assign upd    = head;
`endif

    bp_update_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (lane),
        .rd_en   (deq),
        .rd_data (head),
        .count   (count)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (&clr_idx) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign ovf_sum = {1'b0, ovf_cnt} + 9'(surv_n);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_INIT;
            clr_idx <= '0;
            ovf_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) clr_idx <= clr_idx + INDEX_BITS'(1);
            if (!ready) ovf_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        end
    end

    assign bus.ex_ready_o        = ready;
    assign bus.upd_valid_o       = reset & (deq | byp_en);
    assign bus.upd_is_cond_o     = upd.is_cond;
    assign bus.upd_taken_o       = upd.taken;
    assign bus.upd_gshare_pred_o = upd.gshare_pred;
    assign bus.upd_bi_pred_o     = upd.bi_pred;
    assign bus.upd_mispredict_o  = upd.mispredict;
    assign bus.upd_pc_o          = upd.pc;
    assign bus.upd_target_o      = upd.target;
    assign bus.upd_history_o     = upd.history;
    assign bus.clr_valid_o       = reset & (state == ST_INIT);
    assign bus.clr_idx_o         = clr_idx;
    assign bus.ovf_cnt_o         = ovf_cnt;

endmodule
